// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: bundles the two requester ports and the shared data-bus side of dbus_arbiter.
//   core_* / aux_*  : request (req, we, addr, wdata) in; completion (ack, rdata) out; core_stall out
//   bus_*           : strobes, address, write data and owner toward dmem/uart; bus_rdata back
//   modport slave   : the arbiter's view
//   modport master  : the view of whoever drives requests and models the bus (testbench, SoC glue)
interface dbus_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_ack;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  core_stall;
    logic                  aux_req;
    logic                  aux_we;
    logic [ADDR_WIDTH-1:0] aux_addr;
    logic [DATA_WIDTH-1:0] aux_wdata;
    logic                  aux_ack;
    logic [DATA_WIDTH-1:0] aux_rdata;
    logic                  bus_re;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_owner;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        input  bus_rdata,
        output core_ack, core_rdata, core_stall,
        output aux_ack, aux_rdata,
        output bus_re, bus_we, bus_addr, bus_wdata, bus_owner
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        output bus_rdata,
        input  core_ack, core_rdata, core_stall,
        input  aux_ack, aux_rdata,
        input  bus_re, bus_we, bus_addr, bus_wdata, bus_owner
    );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin arbiter sharing the memory-stage data bus between core and aux.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; aborts any transaction in flight
//   dbus   : dbus_arbiter_if.slave -- core/aux request+ack ports and the shared bus side
//   RD_LAT : cycles from the bus_re cycle until bus_rdata is valid (0..7)
module dbus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input logic           clk,
    input logic           reset,
    dbus_arbiter_if.slave dbus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_core_rdata;
    logic [DATA_WIDTH-1:0] r_aux_rdata;
    logic [2:0]            r_cnt;
    logic                  w_grant;
    logic                  w_grant_owner;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_capture_data;
    logic                  w_access;
    logic                  w_resp;

    always_comb begin
        w_next         = r_state;
        w_grant        = 1'b0;
        w_grant_owner  = r_owner;
        w_capture      = 1'b0;
        w_capture_data = '0;
        case (r_state)
            IDLE: begin
                if (dbus.core_req || dbus.aux_req) begin
                    w_grant       = 1'b1;
                    // on a tie the port that did not own the bus last time wins
                    w_grant_owner = (dbus.core_req && dbus.aux_req) ? !r_owner : dbus.aux_req;
                    w_next        = ACCESS;
                end
            end
            ACCESS: begin
                if (r_we || LAT == 3'd0) begin
                    w_next         = RESP;
                    w_capture      = 1'b1;
                    w_capture_data = r_we ? '0 : dbus.bus_rdata;
                end else begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                // data is valid in the cycle where the counter is about to reach zero
                if (r_cnt == 3'd1) begin
                    w_next         = RESP;
                    w_capture      = 1'b1;
                    w_capture_data = dbus.bus_rdata;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_core_rdata <= '0;
            r_aux_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner <= w_grant_owner;
                r_we    <= w_grant_owner ? dbus.aux_we : dbus.core_we;
                r_addr  <= w_grant_owner ? dbus.aux_addr : dbus.core_addr;
                r_wdata <= w_grant_owner ? dbus.aux_wdata : dbus.core_wdata;
            end
            if (r_state == ACCESS)
                r_cnt <= LAT;
            else if (r_state == WAIT)
                r_cnt <= r_cnt - 3'd1;
            if (w_capture && r_owner)
                r_aux_rdata <= w_capture_data;
            if (w_capture && !r_owner)
                r_core_rdata <= w_capture_data;
        end
    end

    // reset gates strobes and acks combinationally so an aborted access is cut off at once
    assign w_access = (r_state == ACCESS) && !reset;
    assign w_resp   = (r_state == RESP) && !reset;

    assign dbus.bus_re     = w_access && !r_we;
    assign dbus.bus_we     = w_access && r_we;
    assign dbus.bus_addr   = w_access ? r_addr : '0;
    assign dbus.bus_wdata  = w_access ? r_wdata : '0;
    assign dbus.bus_owner  = r_owner;
    assign dbus.core_ack   = w_resp && !r_owner;
    assign dbus.aux_ack    = w_resp && r_owner;
    assign dbus.core_rdata = r_core_rdata;
    assign dbus.aux_rdata  = r_aux_rdata;
    assign dbus.core_stall = dbus.core_req && !dbus.core_ack;
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: three arbiters (RD_LAT 0, 1, 7) driven by directed then random requesters,
// compared every cycle against a transaction-schedule model of grant/strobe/ack timing.
module tb_dbus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       creq, cwe, areq, awe, cack, aack, cstall, bre, bwe, bown;
    logic [2:0][31:0] caddr, cwd, aaddr, awd, crd, ard, baddr, bwd, brd;

    for (genvar g = 0; g < 3; g++) begin : u
        dbus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifc ();
        assign ifc.core_req   = creq[g];
        assign ifc.core_we    = cwe[g];
        assign ifc.core_addr  = caddr[g];
        assign ifc.core_wdata = cwd[g];
        assign ifc.aux_req    = areq[g];
        assign ifc.aux_we     = awe[g];
        assign ifc.aux_addr   = aaddr[g];
        assign ifc.aux_wdata  = awd[g];
        assign ifc.bus_rdata  = brd[g];
        assign cack[g]   = ifc.core_ack;
        assign crd[g]    = ifc.core_rdata;
        assign cstall[g] = ifc.core_stall;
        assign aack[g]   = ifc.aux_ack;
        assign ard[g]    = ifc.aux_rdata;
        assign bre[g]    = ifc.bus_re;
        assign bwe[g]    = ifc.bus_we;
        assign baddr[g]  = ifc.bus_addr;
        assign bwd[g]    = ifc.bus_wdata;
        assign bown[g]   = ifc.bus_owner;
        dbus_arbiter #(
            .DATA_WIDTH(32),
            .ADDR_WIDTH(32),
            .RD_LAT(g == 0 ? 0 : (g == 1 ? 1 : 7))
        ) dut (
            .clk(clk),
            .reset(reset),
            .dbus(ifc.slave)
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // requester state
    bit [2:0] cp, ap, cack_prev, aack_prev;
    int       crq_cyc[3];

    // model: one scheduled transaction per instance
    bit          mbusy[3];
    bit          mown[3];
    bit          mwe[3];
    bit          lown[3];
    int          mgt[3];
    logic [31:0] maddr[3], mwd[3], mdata[3], hc[3], ha[3];
    bit [2:0]    bseen, blast;

    function automatic int lat(input int k);
        return k == 0 ? 0 : (k == 1 ? 1 : 7);
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s inst%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        mbusy[k] = 0;
        lown[k]  = 1;
        hc[k]    = '0;
        ha[k]    = '0;
    endtask

    task automatic check_inst(input int k, input bit r);
        bit strobe, ackn, idle, own;
        int n;
        if (r) begin
            chk("rst_core_ack", k, 32'(cack[k]), 0);
            chk("rst_aux_ack", k, 32'(aack[k]), 0);
            chk("rst_bus_re", k, 32'(bre[k]), 0);
            chk("rst_bus_we", k, 32'(bwe[k]), 0);
            chk("rst_bus_addr", k, baddr[k], 0);
            model_reset(k);
            cack_prev[k] = 0;
            aack_prev[k] = 0;
            return;
        end
        n      = cyc;
        strobe = mbusy[k] && n == mgt[k] + 1;
        ackn   = mbusy[k] && n == mgt[k] + (mwe[k] ? 2 : lat(k) + 2);
        if (mbusy[k] && !mwe[k] && n == mgt[k] + 1 + lat(k))
            mdata[k] = brd[k];
        if (ackn && mown[k])
            ha[k] = mwe[k] ? 32'h0 : mdata[k];
        if (ackn && !mown[k])
            hc[k] = mwe[k] ? 32'h0 : mdata[k];
        chk("bus_we", k, 32'(bwe[k]), 32'(strobe && mwe[k]));
        chk("bus_re", k, 32'(bre[k]), 32'(strobe && !mwe[k]));
        chk("bus_addr", k, baddr[k], strobe ? maddr[k] : 32'h0);
        chk("bus_wdata", k, bwd[k], strobe ? mwd[k] : 32'h0);
        chk("core_ack", k, 32'(cack[k]), 32'(ackn && !mown[k]));
        chk("aux_ack", k, 32'(aack[k]), 32'(ackn && mown[k]));
        chk("core_rdata", k, crd[k], hc[k]);
        chk("aux_rdata", k, ard[k], ha[k]);
        chk("core_stall", k, 32'(cstall[k]), 32'(creq[k] && !(ackn && !mown[k])));
        chk("bus_owner", k, 32'(bown[k]), 32'(lown[k]));
        if (cyc == 3) begin
            chk("reset_owner", k, 32'(bown[k]), 1);
            chk("reset_rdata", k, crd[k], 32'h0);
        end
        if (cyc < 40 && cack[k]) begin
            chk("directed_latency", k, n - crq_cyc[k], cwe[k] ? 2 : (k == 0 ? 2 : (k == 1 ? 3 : 9)));
            if (!cwe[k])
                chk("directed_rdata", k, crd[k], 32'h1234);
        end
        if (cyc < 40 && bwe[k]) begin
            chk("directed_waddr", k, baddr[k], 32'h10);
            chk("directed_wdata", k, bwd[k], 32'hDEADBEEF);
        end
        if (cyc >= 42 && cyc < 80 && (cack[k] || aack[k])) begin
            chk("rr_alternate", k, 32'(aack[k]), bseen[k] ? 32'(!blast[k]) : 32'h0);
            bseen[k] = 1;
            blast[k] = aack[k];
        end
        cack_prev[k] = cack[k];
        aack_prev[k] = aack[k];
        idle = !mbusy[k];
        if (ackn) begin
            mbusy[k] = 0;
        end else if (idle && (creq[k] || areq[k])) begin
            own      = (creq[k] && areq[k]) ? !lown[k] : areq[k];
            mown[k]  = own;
            lown[k]  = own;
            mwe[k]   = own ? awe[k] : cwe[k];
            maddr[k] = own ? aaddr[k] : caddr[k];
            mwd[k]   = own ? awd[k] : cwd[k];
            mgt[k]   = n;
            mbusy[k] = 1;
        end
    endtask

    initial begin
        bit rst_now, want_c, want_a;
        creq = '0; cwe = '0; caddr = '0; cwd = '0;
        areq = '0; awe = '0; aaddr = '0; awd = '0;
        brd = '0; cp = '0; ap = '0; cack_prev = '0; aack_prev = '0;
        bseen = '0; blast = '0;
        for (int k = 0; k < 3; k++)
            model_reset(k);
        repeat (3000) begin
            @(posedge clk);
            cyc++;
            #1;
            rst_now = cyc <= 2 || cyc == 40 || cyc == 41 || cyc == 80 ||
                      (cyc > 80 && $urandom_range(149) == 0);
            reset = rst_now;
            for (int k = 0; k < 3; k++) begin
                if (cack_prev[k]) cp[k] = 0;
                if (aack_prev[k]) ap[k] = 0;
                if (rst_now) begin
                    cp[k] = 0;
                    ap[k] = 0;
                end else begin
                    want_c = cyc < 40 ? (cyc == 5 || cyc == 20) :
                             cyc < 80 ? 1'b1 : ($urandom_range(99) < 35);
                    want_a = cyc < 40 ? 1'b0 :
                             cyc < 80 ? 1'b1 : ($urandom_range(99) < 35);
                    if (!cp[k] && want_c) begin
                        cp[k]      = 1;
                        crq_cyc[k] = cyc;
                        cwe[k]     = cyc < 40 ? (cyc == 5) : 1'($urandom_range(1));
                        caddr[k]   = cyc < 40 ? (cyc == 5 ? 32'h10 : 32'h20) : $urandom;
                        cwd[k]     = cyc < 40 ? 32'hDEADBEEF : $urandom;
                    end
                    if (!ap[k] && want_a) begin
                        ap[k]    = 1;
                        awe[k]   = 1'($urandom_range(1));
                        aaddr[k] = $urandom;
                        awd[k]   = $urandom;
                    end
                end
                creq[k] = cp[k];
                areq[k] = ap[k];
                brd[k]  = cyc < 40 ? 32'h1234 : $urandom;
            end
            #1;
            for (int k = 0; k < 3; k++)
                check_inst(k, rst_now);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
